item_spawner: RTL
=================

ITEM_SPAWNER -- requirements
Module: item_spawner

Interface
REQ-001 Parameter XSIZE, default 48, playfield width in cells.
REQ-002 Parameter YSIZE, default 64, playfield height in cells.
REQ-003 Parameter MAX_SIZE, default 20, body segment capacity.
REQ-004 Parameter SEED, default 16'hACE1, LFSR reset value; SHALL be nonzero.
REQ-005 Parameter MAX_TRY, default 64, candidate rejections before give-up.
REQ-006 i_Clk  in  1  clock; i_Rst  in  1  reset, asynchronous, active-low.
REQ-007 i_Req  in  1  one-cycle request for a new item position.
REQ-008 i_Body_x, i_Body_y  in  MAX_SIZE*6 each  segment coordinates; segment k at bits [6k+5:6k].
REQ-009 i_Size  in  12  current snake length.
REQ-010 o_Item_x, o_Item_y  out  6 each  current item position.
REQ-011 o_Valid  out  1  one-cycle pulse when o_Item_x/o_Item_y have been updated or the attempt was abandoned.
REQ-012 o_Fail  out  1  qualifies o_Valid: attempt abandoned, position unchanged.
REQ-013 o_Busy  out  1  high in every state other than IDLE.

Function
REQ-014 The LFSR SHALL be 16-bit Fibonacci with polynomial x^16+x^14+x^13+x^11+1 and SHALL advance every clock in every state.
REQ-015 FSM states: IDLE, DRAW, CHECK, DONE, in that order of use.
REQ-016 IDLE: i_Req=1 -> latch i_Body_x, i_Body_y, and N=min(i_Size,MAX_SIZE); clear try counter; go to DRAW.
REQ-017 A request while o_Busy=1 SHALL be ignored, with no queuing.
REQ-018 DRAW: candidate cx=lfsr[5:0], cy=lfsr[11:6], latched into registers.
REQ-019 Rejection: cx=0, cx>=XSIZE-1, cy=0, or cy>=YSIZE-1 SHALL count as a rejection and stay in DRAW.
REQ-020 Acceptance: if the candidate is in bounds and N=0, go to DONE; otherwise go to CHECK with index 0.
REQ-021 CHECK SHALL compare exactly one latched segment per cycle (index i).
REQ-022 On a match, CHECK SHALL count a rejection and go to DRAW.
REQ-023 On no match: if i=N-1, go to DONE; otherwise increment i.
REQ-024 Rejection count: each rejection increments the 7-bit try counter.
REQ-025 When the count reaches MAX_TRY, the FSM SHALL go to DONE with the fail flag set.
REQ-026 DONE, success: o_Item_x<=cx, o_Item_y<=cy, o_Valid=1, o_Fail=0; go to IDLE.
REQ-027 DONE, fail: o_Item unchanged, o_Valid=1, o_Fail=1; go to IDLE.
REQ-028 Latency: the first candidate is accepted with no collisions -> o_Valid asserts N+2 cycles after the i_Req sampling edge (N=0 -> 2 cycles).
REQ-029 o_Valid and o_Fail SHALL be registered, and each SHALL be high for exactly one cycle.
REQ-030 o_Item_x and o_Item_y SHALL hold their value between updates.
REQ-031 i_Size > MAX_SIZE SHALL be clamped to MAX_SIZE, with no out-of-range index.

Reset
REQ-032 On i_Rst=0, the block SHALL reset to: o_Item_x=12, o_Item_y=32, o_Valid=0, o_Fail=0, o_Busy=0, state IDLE, LFSR=SEED, counters 0, latched body 0.
REQ-033 Reset mid-operation SHALL abandon the attempt, and no o_Valid SHALL be issued.

Structure
REQ-034 XSIZE, YSIZE, MAX_SIZE, and the FSM state encodings SHALL live in the shared snake game package, used by the top level and the VGA stage.
REQ-035 One sub-module, lfsr16 (parameterised seed, enable tied high), SHALL be used; comparison and FSM logic SHALL stay in item_spawner.

Verification
REQ-036 Reset check: release reset -> o_Item=(12,32), o_Valid=0, o_Busy=0; LFSR sequence matches the bench model from 16'hACE1.
REQ-037 Empty body: i_Size=0, i_Req pulse -> o_Valid exactly 2 cycles later with the model-predicted in-bounds candidate, o_Fail=0.
REQ-038 Full scan: i_Size=3, body (24,32),(24,33),(24,34), model picks a non-colliding first candidate -> o_Valid at +5, item not equal to any segment.
REQ-039 Collision retry: body preloaded with the model's first in-bounds candidate at segment 0 -> CHECK rejects and redraws; final item differs from (24,32); o_Valid delayed accordingly.
REQ-040 Give-up: MAX_TRY overridden to 1 and a collision forced -> o_Valid=1 and o_Fail=1 together, o_Item unchanged.
REQ-041 Robustness: i_Req while busy is ignored (single o_Valid); reset asserted in CHECK -> no o_Valid, outputs return to their reset values; i_Size=100 behaves as 20.

Source files
------------

// File: rtl/item_spawner_pkg.sv
// Shared snake-game definitions: playfield geometry, body capacity,
// spawner defaults, FSM state encoding and the LFSR feedback helper.
package item_spawner_pkg;

  localparam int SNAKE_XSIZE    = 48;
  localparam int SNAKE_YSIZE    = 64;
  localparam int SNAKE_MAX_SIZE = 20;

  localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;
  localparam int          MAX_TRY_DEF   = 64;

  // Item position shown before the first spawn completes
  localparam logic [5:0] ITEM_X_RST = 6'd12;
  localparam logic [5:0] ITEM_Y_RST = 6'd32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAW  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } spawn_state_e;

  // Fibonacci feedback for x^16+x^14+x^13+x^11+1 in right-shift form:
  // the new bit enters at [15] and is the XOR of taps 16,14,13,11.
  function automatic logic lfsr_feedback(input logic [15:0] value);
    return value[0] ^ value[2] ^ value[3] ^ value[5];
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR. The full state stays internal;
// only the 12 low bits used for candidate coordinates leave the block.
module lfsr16
  import item_spawner_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED_DEF
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        enable,
  output logic [11:0] window
);

  logic [15:0] value;

  // Shift register: load the seed on reset, shift in feedback when enabled
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      value <= SEED;
    end else if (enable) begin
      value <= {lfsr_feedback(value), value[15:1]};
    end else begin
      value <= value;
    end
  end

  assign window = value[11:0];

endmodule

// File: rtl/item_spawner.sv
// Picks a random in-bounds playfield cell that is not occupied by the
// snake body. A request latches the body, then candidates are drawn from
// the LFSR and scanned against one body segment per cycle until a free
// cell is found or the retry budget runs out.
module item_spawner
  import item_spawner_pkg::*;
#(
  parameter int          XSIZE    = SNAKE_XSIZE,
  parameter int          YSIZE    = SNAKE_YSIZE,
  parameter int          MAX_SIZE = SNAKE_MAX_SIZE,
  parameter logic [15:0] SEED     = LFSR_SEED_DEF,
  parameter int          MAX_TRY  = MAX_TRY_DEF
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic                  i_Req,
  input  logic [MAX_SIZE*6-1:0] i_Body_x,
  input  logic [MAX_SIZE*6-1:0] i_Body_y,
  input  logic [11:0]           i_Size,
  output logic [5:0]            o_Item_x,
  output logic [5:0]            o_Item_y,
  output logic                  o_Valid,
  output logic                  o_Fail,
  output logic                  o_Busy
);

  localparam int          IW      = (MAX_SIZE > 1) ? $clog2(MAX_SIZE) : 1;
  localparam logic [11:0] MAX_N   = 12'(MAX_SIZE);
  localparam logic [6:0]  X_LIM   = 7'(XSIZE - 1);
  localparam logic [6:0]  Y_LIM   = 7'(YSIZE - 1);
  localparam logic [6:0]  TRY_LIM = 7'(MAX_TRY);

  spawn_state_e state, state_next;

  logic [11:0]   lfsr_window;
  logic [5:0]    cand_x, cand_y;
  logic          cand_bad;

  logic [5:0]    cx, cy, cx_next, cy_next;
  logic [6:0]    try_cnt, try_next;
  logic [IW-1:0] idx, idx_next;
  logic [11:0]   seg_n, seg_n_next;
  logic          fail_flag, fail_next;
  logic          latch_body;

  logic [5:0]    body_x [MAX_SIZE];
  logic [5:0]    body_y [MAX_SIZE];

  logic          seg_hit;
  logic          seg_last;
  logic          try_last;

  lfsr16 #(
    .SEED(SEED)
  ) u_lfsr (
    .i_Clk (i_Clk),
    .i_Rst (i_Rst),
    .enable(1'b1),
    .window(lfsr_window)
  );

  assign cand_x   = lfsr_window[5:0];
  assign cand_y   = lfsr_window[11:6];
  // Border cells and anything past the far wall are never valid spawns
  assign cand_bad = (cand_x == 6'd0) || ({1'b0, cand_x} >= X_LIM) ||
                    (cand_y == 6'd0) || ({1'b0, cand_y} >= Y_LIM);

  // idx only ever walks below seg_n, and seg_n never exceeds MAX_SIZE
  assign seg_hit  = (body_x[idx] == cx) && (body_y[idx] == cy);
  assign seg_last = (12'(idx) == (seg_n - 12'd1));
  assign try_last = ((try_cnt + 7'd1) == TRY_LIM);

  assign o_Busy   = (state != ST_IDLE);

  // Next-state and datapath update decisions for the spawn sequence
  always_comb begin
    state_next = state;
    cx_next    = cx;
    cy_next    = cy;
    try_next   = try_cnt;
    idx_next   = idx;
    seg_n_next = seg_n;
    fail_next  = fail_flag;
    latch_body = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_Req) begin
          latch_body = 1'b1;
          seg_n_next = (i_Size > MAX_N) ? MAX_N : i_Size;
          try_next   = 7'd0;
          idx_next   = '0;
          fail_next  = 1'b0;
          state_next = ST_DRAW;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_DRAW: begin
        cx_next = cand_x;
        cy_next = cand_y;
        if (cand_bad) begin
          try_next = try_cnt + 7'd1;
          if (try_last) begin
            fail_next  = 1'b1;
            state_next = ST_DONE;
          end else begin
            state_next = ST_DRAW;
          end
        end else if (seg_n == 12'd0) begin
          state_next = ST_DONE;
        end else begin
          idx_next   = '0;
          state_next = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (seg_hit) begin
          try_next = try_cnt + 7'd1;
          if (try_last) begin
            fail_next  = 1'b1;
            state_next = ST_DONE;
          end else begin
            state_next = ST_DRAW;
          end
        end else if (seg_last) begin
          state_next = ST_DONE;
        end else begin
          idx_next = idx + IW'(1);
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // FSM state and working registers of the current attempt
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state     <= ST_IDLE;
      cx        <= 6'd0;
      cy        <= 6'd0;
      try_cnt   <= 7'd0;
      idx       <= '0;
      seg_n     <= 12'd0;
      fail_flag <= 1'b0;
    end else begin
      state     <= state_next;
      cx        <= cx_next;
      cy        <= cy_next;
      try_cnt   <= try_next;
      idx       <= idx_next;
      seg_n     <= seg_n_next;
      fail_flag <= fail_next;
    end
  end

  // Snapshot of the body so the scan is immune to movement mid-attempt
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      for (int k = 0; k < MAX_SIZE; k++) begin
        body_x[k] <= 6'd0;
        body_y[k] <= 6'd0;
      end
    end else if (latch_body) begin
      for (int k = 0; k < MAX_SIZE; k++) begin
        body_x[k] <= i_Body_x[6*k +: 6];
        body_y[k] <= i_Body_y[6*k +: 6];
      end
    end else begin
      for (int k = 0; k < MAX_SIZE; k++) begin
        body_x[k] <= body_x[k];
        body_y[k] <= body_y[k];
      end
    end
  end

  // Registered result: one-cycle valid/fail pulse, item kept on failure
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      o_Item_x <= ITEM_X_RST;
      o_Item_y <= ITEM_Y_RST;
      o_Valid  <= 1'b0;
      o_Fail   <= 1'b0;
    end else if (state == ST_DONE) begin
      o_Valid <= 1'b1;
      o_Fail  <= fail_flag;
      if (!fail_flag) begin
        o_Item_x <= cx;
        o_Item_y <= cy;
      end else begin
        o_Item_x <= o_Item_x;
        o_Item_y <= o_Item_y;
      end
    end else begin
      o_Valid  <= 1'b0;
      o_Fail   <= 1'b0;
      o_Item_x <= o_Item_x;
      o_Item_y <= o_Item_y;
    end
  end

endmodule
